// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit:
// FSM states, datapath mux select codes and the next-state rule.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // i_bit is Funct[5] (immediate operand), l_bit is Funct[0] (load vs store).
    function automatic state_t next_state(input state_t s, input logic [1:0] op,
                                          input logic i_bit, input logic l_bit);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:    n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_DP:   n = i_bit ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  n = S_MEMADR;
                    OP_BR:   n = S_BRANCH;
                    default: n = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   n = l_bit ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  n = S_MEMWB;
            S_EXECUTER: n = S_ALUWB;
            S_EXECUTEI: n = S_ALUWB;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decode: selects the ALU operation and raw flag-write
// enables during execute, and flags CMP as a non-writing instruction.
module alu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic       ALUOp,
    input  logic [1:0] Op,
    input  logic [3:0] cmd,
    input  logic       s_bit,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite
);

    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        if (ALUOp) begin
            case (cmd)
                CMD_ADD: begin
                    ALUControl = ALU_ADD;
                    FlagW      = {s_bit, s_bit};
                end
                CMD_SUB: begin
                    ALUControl = ALU_SUB;
                    FlagW      = {s_bit, s_bit};
                end
                CMD_AND: begin
                    ALUControl = ALU_AND;
                    FlagW      = {s_bit, 1'b0};
                end
                CMD_ORR: begin
                    ALUControl = ALU_ORR;
                    FlagW      = {s_bit, 1'b0};
                end
                // CMP exists only to set flags, so it writes all of them.
                CMD_CMP: begin
                    ALUControl = ALU_SUB;
                    FlagW      = 2'b11;
                end
                default: begin
                    ALUControl = ALU_ADD;
                    FlagW      = 2'b00;
                end
            endcase
        end
    end

    // Independent of state so condlogic can rely on it across ALUWB.
    assign NoWrite = (Op == OP_DP) && (cmd == CMD_CMP);

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle ARM control unit: state register, next-state sequencing and
// Moore output decode producing raw (unconditioned) write requests.
module mc_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite
);

    state_t state;
    logic   reg_w;
    logic   branch;
    logic   alu_op;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state(state, Op, Funct[5], Funct[0]);
        end
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        reg_w     = 1'b0;
        MemW      = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            // DECODE precomputes PC+8 on the same path FETCH used.
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_EXTIMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                reg_w     = 1'b1;
                ResultSrc = RES_DATA;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: begin
                alu_op = 1'b1;
            end
            S_EXECUTEI: begin
                alu_op  = 1'b1;
                ALUSrcB = SRCB_EXTIMM;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
            end
            S_BRANCH: begin
                branch    = 1'b1;
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .Op         (Op),
        .cmd        (Funct[4:1]),
        .s_bit      (Funct[0]),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .NoWrite    (NoWrite)
    );

    // A write to R15 redirects the PC, so it is reported as a PC write too.
    assign PCS    = branch | (reg_w & (Rd == 4'hF));
    assign RegW   = reg_w;
    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};

    assert property (@(posedge clk) disable iff (!reset) $onehot0({reg_w, MemW, branch}));

endmodule
